// File: rtl/lc3_io_pkg.sv
// Shared types and constants for the LC-3 board input-conditioning logic.
package lc3_io_pkg;

   // Per-button debounce FSM states
   typedef enum logic [1:0] {
      IDLE,
      PRESS_CNT,
      HELD,
      REL_CNT
   } btn_state_t;

   // Flops in every asynchronous-input synchronizer chain
   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/btn_debounce.sv
// One active-low pushbutton: synchronizer, debounce FSM, one-cycle active-low
// pulse per accepted press, and a debounced held level. With REPEAT_EN set, a
// held button re-pulses every REPEAT_CYCLES cycles. DB_CYCLES must be >= 2.
module btn_debounce
   import lc3_io_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = 16,
   parameter bit          REPEAT_EN     = 1'b0,
   parameter int unsigned REPEAT_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_ni,
   output logic pulse_no,
   output logic held_o
);

   localparam int unsigned    CntW    = $clog2(DB_CYCLES) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);
   localparam logic [CntW-1:0] CntMax  = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   btn_state_t             state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
   logic                   held_q, held_d;
   logic                   pulse_q, pulse_d;
   logic                   accept;
   logic                   rep_fire;

   assign synced  = sync_q[SYNC_STAGES-1];
   // Saturating increment so the counter can never wrap back into range
   assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

   // State register; buttons reset to released and the FSM to REL_CNT so a
   // button held through reset is absorbed without a pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '1;
         state_q <= REL_CNT;
         cnt_q   <= '0;
         held_q  <= 1'b0;
         pulse_q <= 1'b1;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_ni};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         held_q  <= held_d;
         pulse_q <= pulse_d;
      end
   end

   // Next-state: count consecutive stable synced samples in each direction
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!synced) begin
               state_d = PRESS_CNT;
               cnt_d   = CntW'(1);
            end
         end
         PRESS_CNT: begin
            if (synced) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q >= CntLast) begin
               state_d = HELD;
               cnt_d   = '0;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (synced) begin
               state_d = REL_CNT;
               cnt_d   = CntW'(1);
            end
         end
         REL_CNT: begin
            if (!synced) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q >= CntLast) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = REL_CNT;
            cnt_d   = '0;
         end
      endcase
   end

   generate
      if (REPEAT_EN) begin : g_repeat
         localparam int unsigned    RepW    = $clog2(REPEAT_CYCLES) + 1;
         localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
         logic [RepW-1:0] rep_q;
         logic            stay_held;

         assign stay_held = (state_q == HELD) && (state_d == HELD);
         assign rep_fire  = stay_held && (rep_q >= RepLast);

         // Repeat timer runs only while HELD persists; any exit clears it
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               rep_q <= '0;
            end else if (stay_held) begin
               rep_q <= (rep_q >= RepLast) ? '0 : rep_q + 1'b1;
            end else begin
               rep_q <= '0;
            end
         end
      end else begin : g_no_repeat
         assign rep_fire = 1'b0;
      end
   endgenerate

   // Outputs: registered pulse and held level; held drops only at IDLE
   always_comb begin
      pulse_d = ~(accept | rep_fire);
      held_d  = held_q;
      if (state_d == HELD) begin
         held_d = 1'b1;
      end else if (state_d == IDLE) begin
         held_d = 1'b0;
      end
      pulse_no = pulse_q;
      held_o   = held_q;
   end

endmodule

// File: rtl/lc3_input_conditioner.sv
// Board input conditioning ahead of the LC-3 top: debounced one-cycle
// active-low Run/Continue pulses and 2-flop synchronized switches.
// Build option: define LC3_BTN_AUTOREPEAT_EN to make a held Continue
// auto-repeat every REPEAT_CYCLES cycles.
module lc3_input_conditioner
   import lc3_io_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = 16,
   parameter int unsigned SW_WIDTH      = 16,
   parameter int unsigned REPEAT_CYCLES = 64
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Run_raw,
   input  logic                Continue_raw,
   input  logic [SW_WIDTH-1:0] S_raw,
   output logic                Run,
   output logic                Continue,
   output logic [SW_WIDTH-1:0] S,
   output logic [1:0]          btn_held
);

`ifdef LC3_BTN_AUTOREPEAT_EN
   localparam bit ContRepeat = 1'b1;
`else
   localparam bit ContRepeat = 1'b0;
`endif

   logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] s_pipe_q;

   btn_debounce #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_EN     (1'b0),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_run (
      .clk_i    (Clk),
      .rst_ni   (Reset),
      .raw_ni   (Run_raw),
      .pulse_no (Run),
      .held_o   (btn_held[0])
   );

   btn_debounce #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_EN     (ContRepeat),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_continue (
      .clk_i    (Clk),
      .rst_ni   (Reset),
      .raw_ni   (Continue_raw),
      .pulse_no (Continue),
      .held_o   (btn_held[1])
   );

   // Switch synchronizer: plain 2-flop chain per bit, no debounce
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         s_pipe_q <= '0;
      end else begin
         s_pipe_q <= {s_pipe_q[SYNC_STAGES-2:0], S_raw};
      end
   end

   assign S = s_pipe_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_lc3_input_conditioner.sv
// Scoreboard bench for lc3_input_conditioner (DB_CYCLES=4, REPEAT_CYCLES=8).
// Expected pulse cycles and switch changes are queued by the stimulus; a
// negedge monitor pops and compares whenever an output event appears.
module tb_lc3_input_conditioner;

   localparam int unsigned DB  = 4;
   localparam int unsigned SW  = 16;
   localparam int unsigned RPT = 8;

   typedef struct {
      logic [SW-1:0] val;
      int            at;
   } s_exp_t;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          Run_raw, Continue_raw;
   logic [SW-1:0] S_raw;
   logic          Run, Continue;
   logic [SW-1:0] S;
   logic [1:0]    btn_held;

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     run_q[$];
   int     cont_q[$];
   s_exp_t s_q[$];
   logic [SW-1:0] s_prev = '0;
   int     run_e, cont_e;
   s_exp_t s_e;
   int     c0;

   lc3_input_conditioner #(
      .DB_CYCLES     (DB),
      .SW_WIDTH      (SW),
      .REPEAT_CYCLES (RPT)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Run_raw      (Run_raw),
      .Continue_raw (Continue_raw),
      .S_raw        (S_raw),
      .Run          (Run),
      .Continue     (Continue),
      .S            (S),
      .btn_held     (btn_held)
   );

   always #5 Clk = ~Clk;

   // Edge counter: after posedge N, cyc == N
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every low pulse and every switch change must match the queue head
   always @(negedge Clk) begin
      if (Run !== 1'b1 && Reset === 1'b1) begin
         checks++;
         if (run_q.size() == 0) begin
            errors++;
            $display("FAIL run_pulse: got Run=%b at cycle %0d, expected no pulse", Run, cyc);
         end else begin
            run_e = run_q.pop_front();
            if (run_e != cyc || Run !== 1'b0) begin
               errors++;
               $display("FAIL run_pulse: got Run=%b at cycle %0d, expected 0 at cycle %0d",
                        Run, cyc, run_e);
            end
         end
      end
      if (Continue !== 1'b1 && Reset === 1'b1) begin
         checks++;
         if (cont_q.size() == 0) begin
            errors++;
            $display("FAIL cont_pulse: got Continue=%b at cycle %0d, expected no pulse",
                     Continue, cyc);
         end else begin
            cont_e = cont_q.pop_front();
            if (cont_e != cyc || Continue !== 1'b0) begin
               errors++;
               $display("FAIL cont_pulse: got Continue=%b at cycle %0d, expected 0 at cycle %0d",
                        Continue, cyc, cont_e);
            end
         end
      end
      if (S !== s_prev) begin
         checks++;
         if (s_q.size() == 0) begin
            errors++;
            $display("FAIL s_change: got S=%h at cycle %0d, expected no change", S, cyc);
         end else begin
            s_e = s_q.pop_front();
            if (s_e.val !== S || s_e.at != cyc) begin
               errors++;
               $display("FAIL s_change: got S=%h at cycle %0d, expected %h at cycle %0d",
                        S, cyc, s_e.val, s_e.at);
            end
         end
         s_prev = S;
      end
   end

   initial begin
      Run_raw      = 1'b0;
      Continue_raw = 1'b1;
      S_raw        = '0;
      #1 Reset = 1'b0;

      // 1: Run held through reset release -> no pulse, held after sync + 1 sample
      repeat (2) @(negedge Clk);
      chk("reset_run", 32'(Run), 32'd1);
      chk("reset_cont", 32'(Continue), 32'd1);
      chk("reset_s", 32'(S), 32'd0);
      chk("reset_held", 32'(btn_held), 32'd0);
      Reset = 1'b1;
      repeat (5) @(negedge Clk);
      chk("t1_held_run", 32'(btn_held[0]), 32'd1);
      chk("t1_held_cont", 32'(btn_held[1]), 32'd0);
      // Release: REL_CNT needs DB high samples, held drops on the 6th edge
      Run_raw = 1'b1;
      repeat (5) @(negedge Clk);
      chk("rel_still_held", 32'(btn_held[0]), 32'd1);
      @(negedge Clk);
      chk("rel_dropped", 32'(btn_held[0]), 32'd0);
      repeat (4) @(negedge Clk);

      // 2: clean press -> single pulse DB+1 edges after first low sample
      Run_raw = 1'b0;
      run_q.push_back(cyc + DB + 2);
      repeat (DB + 3) @(negedge Clk);
      chk("t2_held", 32'(btn_held[0]), 32'd1);
      repeat (100) @(negedge Clk);
      Run_raw = 1'b1;
      repeat (10) @(negedge Clk);
      chk("t2_released", 32'(btn_held[0]), 32'd0);

      // 3: bouncing Continue never pulses
      for (int i = 0; i < 5; i++) begin
         Continue_raw = 1'b0;
         repeat (2) @(negedge Clk);
         Continue_raw = 1'b1;
         repeat (2) @(negedge Clk);
      end
      repeat (6) @(negedge Clk);
      chk("t3_not_held", 32'(btn_held[1]), 32'd0);

      // Boundary: DB-1 low cycles rejected, exactly DB accepted
      Continue_raw = 1'b0;
      repeat (DB - 1) @(negedge Clk);
      Continue_raw = 1'b1;
      repeat (10) @(negedge Clk);
      chk("short_not_held", 32'(btn_held[1]), 32'd0);
      Continue_raw = 1'b0;
      cont_q.push_back(cyc + DB + 2);
      repeat (DB) @(negedge Clk);
      Continue_raw = 1'b1;
      repeat (12) @(negedge Clk);
      chk("min_press_idle", 32'(btn_held[1]), 32'd0);

      // 4: simultaneous presses pulse together, once each
      Run_raw      = 1'b0;
      Continue_raw = 1'b0;
      run_q.push_back(cyc + DB + 2);
      cont_q.push_back(cyc + DB + 2);
      repeat (8) @(negedge Clk);
      chk("t4_held_both", 32'(btn_held), 32'd3);
      Run_raw      = 1'b1;
      Continue_raw = 1'b1;
      repeat (12) @(negedge Clk);
      chk("t4_idle_both", 32'(btn_held), 32'd0);

      // 5: switches follow two edges later with no intermediate values
      S_raw = 16'h005A;
      s_q.push_back('{16'h005A, cyc + 2});
      repeat (5) @(negedge Clk);
      S_raw = 16'h0003;
      s_q.push_back('{16'h0003, cyc + 2});
      repeat (5) @(negedge Clk);
      chk("t5_s_value", 32'(S), 32'h0003);
      S_raw = 16'h0000;
      s_q.push_back('{16'h0000, cyc + 2});
      repeat (5) @(negedge Clk);

      // Reset mid-count drops the press; FSM re-enters HELD without a pulse
      Run_raw = 1'b0;
      repeat (3) @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("midrst_run", 32'(Run), 32'd1);
      chk("midrst_held", 32'(btn_held), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      repeat (6) @(negedge Clk);
      chk("midrst_reheld", 32'(btn_held[0]), 32'd1);
      Run_raw = 1'b1;
      repeat (10) @(negedge Clk);

      // 6: long holds; Continue repeats only with auto-repeat built in
      c0 = cyc;
      Run_raw      = 1'b0;
      Continue_raw = 1'b0;
      run_q.push_back(c0 + DB + 2);
      cont_q.push_back(c0 + DB + 2);
`ifdef LC3_BTN_AUTOREPEAT_EN
      cont_q.push_back(c0 + DB + 2 + RPT);
      cont_q.push_back(c0 + DB + 2 + 2 * RPT);
      cont_q.push_back(c0 + DB + 2 + 3 * RPT);
`endif
      repeat (33) @(negedge Clk);
      Run_raw      = 1'b1;
      Continue_raw = 1'b1;
      repeat (15) @(negedge Clk);
      chk("t6_idle_both", 32'(btn_held), 32'd0);

      // Every queued expectation must have been consumed
      chk("run_q_drained", 32'(run_q.size()), 32'd0);
      chk("cont_q_drained", 32'(cont_q.size()), 32'd0);
      chk("s_q_drained", 32'(s_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
